// File: rtl/padout_strobe_pkg.sv
// ---------------------------------------------------------------------------
// padout_strobe_pkg
//
// Shared definitions for the strobed pad output port:
//   - 3-bit FSM state encoding for the transfer sequencer
//   - CNT_W, the width of the shared SETUP/STROBE/WAIT_ACK down-counter
//   - cnt_load(), which converts a cycle count into a counter preload value
//
// No ports; imported by padout_strobe_port and padout_fifo.
// ---------------------------------------------------------------------------
package padout_strobe_pkg;

  localparam int CNT_W = 8;

  localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
  localparam logic [2:0] ST_SETUP_ENC    = 3'd1;
  localparam logic [2:0] ST_STROBE_ENC   = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK_ENC = 3'd3;
  localparam logic [2:0] ST_HOLD_ENC     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_SETUP    = ST_SETUP_ENC,
    ST_STROBE   = ST_STROBE_ENC,
    ST_WAIT_ACK = ST_WAIT_ACK_ENC,
    ST_HOLD     = ST_HOLD_ENC
  } state_t;

  // The counter counts down to zero and the phase ends on the cycle it reads
  // zero, so a phase lasting n cycles is preloaded with n-1.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/padout_fifo.sv
// ---------------------------------------------------------------------------
// padout_fifo
//
// Small synchronous FIFO that buffers core words ahead of the pad sequencer.
// Read data is the current head (first-word fall-through), so the consumer
// can capture it in the same cycle it pops.
//
// Parameters:
//   M, N   : data MSB / LSB index, width W = M-N+1
//   DEPTH  : number of entries, power of 2, >= 2
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, empties the FIFO
//   push   : write wdata at the tail (ignored when full)
//   pop    : drop the head entry (ignored when empty)
//   wdata  : word to write
//   rdata  : current head word
//   count  : number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module padout_fifo
  import padout_strobe_pkg::*;
#(
  parameter int M     = 7,
  parameter int N     = 0,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [M:N]               wdata,
  output logic [M:N]               rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [M:N]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;

  // A full FIFO refuses a push even when a pop frees a slot in the same
  // cycle; this keeps WREADY a pure function of the count.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/padout_strobe_port.sv
// ---------------------------------------------------------------------------
// padout_strobe_port
//
// Strobed parallel output port feeding the padout_n IN0 inputs. Words from
// the core are buffered in padout_fifo, then each word is driven on OUT_DATA,
// held for SETUP_CYC cycles, framed by a PULSE_CYC-wide OUT_STB pulse, and
// followed by a wait for a rising edge on the asynchronous ACK_IN. A missing
// acknowledge within TMO_CYC cycles drops the word and sets the sticky ERR.
//
// Parameters:
//   M, N       : data MSB / LSB index
//   DEPTH      : FIFO entries, power of 2, >= 2
//   SETUP_CYC  : data-stable cycles before the strobe rises, >= 1
//   PULSE_CYC  : strobe high cycles, >= 1
//   TMO_CYC    : acknowledge timeout in cycles, 1..255
//
// Ports:
//   CLK      : clock, rising edge
//   RST_N    : asynchronous active-low reset
//   WDATA    : word from core
//   WVALID   : WDATA valid
//   WREADY   : FIFO can accept a word
//   OUT_DATA : registered data to pad
//   OUT_STB  : registered strobe to pad
//   ACK_IN   : acknowledge from input pad, asynchronous
//   BUSY     : FIFO non-empty or sequencer active
//   ERR      : sticky acknowledge-timeout flag
//   ERR_CLR  : synchronous clear of ERR
// ---------------------------------------------------------------------------
module padout_strobe_port
  import padout_strobe_pkg::*;
#(
  parameter int M         = 7,
  parameter int N         = 0,
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int TMO_CYC   = 255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [M:N] WDATA,
  input  logic       WVALID,
  output logic       WREADY,
  output logic [M:N] OUT_DATA,
  output logic       OUT_STB,
  input  logic       ACK_IN,
  output logic       BUSY,
  output logic       ERR,
  input  logic       ERR_CLR
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] SETUP_LOAD = cnt_load(SETUP_CYC);
  localparam logic [CNT_W-1:0] PULSE_LOAD = cnt_load(PULSE_CYC);
  localparam logic [CNT_W-1:0] TMO_LOAD   = cnt_load(TMO_CYC);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [AW:0]      fifo_count;
  logic [M:N]       fifo_rdata;
  logic             fifo_push;
  logic             fifo_pop;

  logic             ack_meta;
  logic             ack_s;
  logic             ack_d;
  logic             ack_rise;

  assign WREADY    = (fifo_count < (AW+1)'(DEPTH));
  assign fifo_push = WVALID && WREADY;
  assign fifo_pop  = (state == ST_IDLE) && (fifo_count != '0);
  assign BUSY      = (state != ST_IDLE) || (fifo_count != '0);

  padout_fifo #(
    .M     (M),
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (WDATA),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  // Two-flop synchroniser for the pad acknowledge, plus one more stage so a
  // level held high from an earlier transfer never reads as a fresh edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
      ack_d    <= 1'b0;
    end else begin
      ack_meta <= ACK_IN;
      ack_s    <= ack_meta;
      ack_d    <= ack_s;
    end
  end

  assign ack_rise = ack_s && !ack_d;

  // Transfer sequencer. One down-counter is reused for the setup, strobe and
  // acknowledge-timeout phases. ERR_CLR is applied first so that a timeout
  // in the same cycle overrides it and the flag stays set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      OUT_DATA <= '0;
      OUT_STB  <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      if (ERR_CLR) begin
        ERR <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            OUT_DATA <= fifo_rdata;
            cnt      <= SETUP_LOAD;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            OUT_STB <= 1'b1;
            cnt     <= PULSE_LOAD;
            state   <= ST_STROBE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            OUT_STB <= 1'b0;
            cnt     <= TMO_LOAD;
            state   <= ST_WAIT_ACK;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (ack_rise) begin
            state <= ST_HOLD;
          end else if (cnt == '0) begin
            ERR   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_HOLD: begin
          state <= ST_IDLE;
        end
        default: begin
          OUT_STB <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_padout_strobe_port.sv
// ---------------------------------------------------------------------------
// tb_padout_strobe_port
//
// Directed self-checking bench for padout_strobe_port. Inputs change 1 ns
// after each rising edge and outputs are sampled at the same point, so a
// value sampled "after edge k" is the state the DUT holds through cycle k.
// ---------------------------------------------------------------------------
module tb_padout_strobe_port;

  localparam int M         = 7;
  localparam int N         = 0;
  localparam int DEPTH     = 4;
  localparam int SETUP_CYC = 2;
  localparam int PULSE_CYC = 2;
  localparam int TMO_CYC   = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wdata;
  logic       wvalid;
  logic       wready;
  logic [7:0] out_data;
  logic       out_stb;
  logic       ack_in;
  logic       busy;
  logic       err;
  logic       err_clr;

  int check_count = 0;
  int pass_count  = 0;

  padout_strobe_port #(
    .M         (M),
    .N         (N),
    .DEPTH     (DEPTH),
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .TMO_CYC   (TMO_CYC)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .WDATA    (wdata),
    .WVALID   (wvalid),
    .WREADY   (wready),
    .OUT_DATA (out_data),
    .OUT_STB  (out_stb),
    .ACK_IN   (ack_in),
    .BUSY     (busy),
    .ERR      (err),
    .ERR_CLR  (err_clr)
  );

  always #5 clk = ~clk;

  // Absolute time limit so a wedged DUT still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_count, check_count);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] data,
                               input logic ack, input logic clr);
    wvalid  = valid;
    wdata   = data;
    ack_in  = ack;
    err_clr = clr;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Waits (bounded) for the strobe to reach a level; an expired bound shows
  // up as a failed comparison on the strobe itself.
  task automatic waitStrobe(input logic level, input string tag);
    int n = 0;
    while (out_stb !== level && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, out_stb, level);
  endtask

  // Completes one transfer with an acknowledge: waits for the strobe, checks
  // the word, raises ACK right after the strobe falls, and returns once the
  // sequencer is back in IDLE (HOLD is three edges after the ACK edge).
  task automatic ackTransfer(input logic [7:0] exp_data, input logic keep_high);
    waitStrobe(1'b1, "xfer_stb_rise");
    checkOutput("xfer_data", out_data, exp_data);
    waitStrobe(1'b0, "xfer_stb_fall");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("xfer_hold_busy", busy, 1'b1);
    if (!keep_high) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    tick();
  endtask

  initial begin
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    checkOutput("rst_out_stb", out_stb, 1'b0);
    checkOutput("rst_out_data", out_data, 8'h00);
    checkOutput("rst_wready", wready, 1'b1);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single transfer of A5, push at edge t, ACK rising at edge t+9.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("single_wready", wready, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("single_t0_busy", busy, 1'b1);
    checkOutput("single_t0_data", out_data, 8'h00);
    tick();
    checkOutput("single_t1_data", out_data, 8'hA5);
    checkOutput("single_t1_stb", out_stb, 1'b0);
    tick();
    checkOutput("single_t2_stb", out_stb, 1'b0);
    tick();
    checkOutput("single_t3_stb", out_stb, 1'b1);
    tick();
    checkOutput("single_t4_stb", out_stb, 1'b1);
    tick();
    checkOutput("single_t5_stb", out_stb, 1'b0);
    checkOutput("single_t5_busy", busy, 1'b1);
    repeat (4) tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (2) tick();
    checkOutput("single_t11_busy", busy, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkOutput("single_t12_hold_busy", busy, 1'b1);
    tick();
    checkOutput("single_t13_busy", busy, 1'b0);
    checkOutput("single_t13_data", out_data, 8'hA5);
    checkOutput("single_t13_err", err, 1'b0);
    repeat (3) tick();

    // Fill: WVALID held high, words 10..14 accepted on edges e0..e4.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      checkOutput("fill_wready", wready, 1'b1);
      tick();
    end
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    checkOutput("full_wready", wready, 1'b0);
    checkOutput("full_busy", busy, 1'b1);
    checkOutput("full_inflight_data", out_data, 8'h10);

    // First word times out at e21 (WAIT_ACK entered at e5); ERR_CLR in the
    // same cycle must lose. At e22 a pop at full must refuse the pending 99.
    repeat (16) tick();
    checkOutput("tmo_e20_err", err, 1'b0);
    checkOutput("tmo_e20_wready", wready, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    tick();
    checkOutput("tmo_e21_err_set_wins", err, 1'b1);
    checkOutput("tmo_e21_wready", wready, 1'b0);
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
    tick();
    checkOutput("popfull_wready", wready, 1'b1);
    checkOutput("tmo_next_word", out_data, 8'h11);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    ackTransfer(8'h11, 1'b0);
    ackTransfer(8'h12, 1'b0);
    ackTransfer(8'h13, 1'b0);
    ackTransfer(8'h14, 1'b0);
    checkOutput("drain_busy", busy, 1'b0);
    checkOutput("drain_wready", wready, 1'b1);
    checkOutput("drain_err_sticky", err, 1'b1);
    checkOutput("drain_last_data", out_data, 8'h14);

    // ERR_CLR alone clears the flag.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("errclr_err", err, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();

    // Stale ACK: acknowledge 3C and keep ACK high; C3 must then time out.
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    ackTransfer(8'h3C, 1'b1);
    checkOutput("stale_first_busy", busy, 1'b0);
    checkOutput("stale_first_err", err, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    waitStrobe(1'b1, "stale_stb_rise");
    checkOutput("stale_data", out_data, 8'hC3);
    waitStrobe(1'b0, "stale_stb_fall");
    repeat (TMO_CYC - 1) tick();
    checkOutput("stale_pre_tmo_err", err, 1'b0);
    checkOutput("stale_pre_tmo_busy", busy, 1'b1);
    tick();
    checkOutput("stale_tmo_err", err, 1'b1);
    checkOutput("stale_tmo_busy", busy, 1'b0);

    // Reset in the middle of STROBE with another word still queued.
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 8'h78, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    waitStrobe(1'b1, "midrst_stb_rise");
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_stb_async", out_stb, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checkOutput("postrst_wready", wready, 1'b1);
    checkOutput("postrst_busy", busy, 1'b0);
    checkOutput("postrst_err", err, 1'b0);
    checkOutput("postrst_stb", out_stb, 1'b0);
    checkOutput("postrst_data", out_data, 8'h00);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
